// File: rtl/relu_scale_buffer_pkg.sv
// Shared types and constants for the ReLU/scale word buffer.
// Lane geometry, FSM states and lane saturation limits.
package relu_scale_buffer_pkg;

  localparam int LANE_W = 16;
  localparam int LANES  = 4;

  localparam logic [LANE_W-1:0] LANE_MAX = 16'h7FFF;
  localparam logic [LANE_W-1:0] LANE_MIN = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/relu_scale_buffer_lane.sv
// One 16-bit lane: signed multiply, arithmetic shift, ReLU and clip.
// Purely combinational; four copies form the write-back stage.
module lane_relu_scale
  import relu_scale_buffer_pkg::*;
#(
  parameter logic signed [15:0] SCALE = 16'sd384,
  parameter int                 SHIFT = 8
) (
  input  logic [LANE_W-1:0] lane,
  output logic [LANE_W-1:0] result
);

  logic signed [31:0] prod;
  logic signed [31:0] shifted;

  assign prod    = $signed(lane) * SCALE;
  assign shifted = prod >>> SHIFT;

  // Negative goes to zero, anything past the signed 16-bit max saturates.
  always_comb begin
    result = shifted[LANE_W-1:0];
    if (shifted < 0) begin
      result = LANE_MIN;
    end else if (shifted > 32'sd32767) begin
      result = LANE_MAX;
    end
  end

endmodule

// File: rtl/relu_scale_buffer.sv
// Word buffer: load words, scale+ReLU them in place, serve results.
// Compute is a 2-stage read / write-back walk over all words.
module relu_scale_buffer
  import relu_scale_buffer_pkg::*;
#(
  parameter int                 MEM_DEPTH  = 21,
  parameter int                 ADDR_WIDTH = 5,
  parameter int                 DATA_WIDTH = 64,
  parameter logic signed [15:0] SCALE      = 16'sd384,
  parameter int                 SHIFT      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  finish,
  input  logic                  en_out,
  input  logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]      cnt;
  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] wb_data;

  logic load_we;
  logic issue;
  logic in_ok;
  logic out_ok;

  assign in_ok  = {1'b0, in_addr} < DEPTH_C;
  assign out_ok = {1'b0, out_addr} < DEPTH_C;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: load while start is high, then walk, then park in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (!start) state_next = COMPUTE;
      COMPUTE: if (cnt == DEPTH_C && !s1_valid) state_next = DONE;
      DONE:    if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and strobes decoded from the current state.
  always_comb begin
    finish  = (state == DONE);
    load_we = 1'b0;
    issue   = 1'b0;
    if (!rst) begin
      load_we = start && in_ok && (state != COMPUTE);
      issue   = ((state == LOAD) && !start) ||
                ((state == COMPUTE) && (cnt < DEPTH_C));
    end
  end

  // Stage 1: issue one read per cycle; cnt is zero outside the walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_addr <= cnt[ADDR_WIDTH-1:0];
        s1_data <= mem[cnt[ADDR_WIDTH-1:0]];
        cnt     <= cnt + 1'b1;
      end else if (state != COMPUTE) begin
        cnt <= '0;
      end
    end
  end

  // Stage 2 datapath: four independent lanes.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    lane_relu_scale #(
      .SCALE (SCALE),
      .SHIFT (SHIFT)
    ) u_lane (
      .lane   (s1_data[j*LANE_W +: LANE_W]),
      .result (wb_data[j*LANE_W +: LANE_W])
    );
  end

  // Single write port: loader and write-back never overlap in time.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[in_addr] <= din;
    end else if (s1_valid && !rst) begin
      mem[s1_addr] <= wb_data;
    end
  end

  // Registered read port; out-of-range addresses read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (en_out) begin
      dout <= out_ok ? mem[out_addr] : '0;
    end
  end

endmodule

// File: tb/tb_relu_scale_buffer.sv
// Directed bench for relu_scale_buffer.
// Loads frames, times finish, reads back and compares.
module tb_relu_scale_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  in_addr;
  logic [63:0] din;
  logic        finish;
  logic        en_out;
  logic [4:0]  out_addr;
  logic [63:0] dout;

  int checks = 0;
  int errors = 0;

  logic [63:0] fa [21];
  logic [63:0] ea [21];
  logic [63:0] fb [21];
  logic [63:0] eb [21];
  logic [63:0] fd [21];
  logic [63:0] ed [21];

  relu_scale_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_addr  (in_addr),
    .din      (din),
    .finish   (finish),
    .en_out   (en_out),
    .out_addr (out_addr),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // x*384>>>8 == floor(1.5*x) for x>=0, then clip.
  function automatic logic [15:0] lane_ref(input logic [15:0] x);
    int v;
    v = $signed(x);
    if (v < 0) return 16'h0000;
    v = (v * 3) / 2;
    if (v > 32767) return 16'h7FFF;
    return v[15:0];
  endfunction

  function automatic logic [63:0] word_ref(input logic [63:0] w);
    return {lane_ref(w[63:48]), lane_ref(w[47:32]),
            lane_ref(w[31:16]), lane_ref(w[15:0])};
  endfunction

  task automatic load_frame(input logic [63:0] w [21], input bit bad);
    start = 1'b1;
    for (int k = 0; k < 21; k++) begin
      if (bad && k == 10) begin
        in_addr = 5'd25;
        din     = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
      end
      in_addr = 5'(k);
      din     = w[k];
      tick();
      if (k == 0) check("finish_load", {63'd0, finish}, 64'd0);
    end
    start   = 1'b0;
    in_addr = '0;
    din     = '0;
  endtask

  task automatic wait_finish(input bit pulse);
    int n;
    n = 0;
    while (n < 60) begin
      if (pulse && n == 5) start = 1'b1;
      if (pulse && n == 6) start = 1'b0;
      tick();
      n++;
      if (finish) break;
    end
    start = 1'b0;
    check("finish_latency", 64'(n), 64'd23);
  endtask

  task automatic read_all(input logic [63:0] e [21]);
    for (int k = 0; k < 21; k++) begin
      out_addr = 5'(k);
      en_out   = 1'b1;
      tick();
      check($sformatf("rd%0d", k), dout, e[k]);
    end
    out_addr = 5'd21;
    tick();
    check("rd_oob", dout, 64'd0);
    en_out = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_addr  = '0;
    din      = '0;
    en_out   = 1'b0;
    out_addr = '0;

    for (int k = 0; k < 21; k++) begin
      fa[k] = {4{16'h0100}};
      ea[k] = {4{16'h0180}};
      fb[k] = {16'h1235, 16'(-k), 16'(k * 2000), 16'(k * 1000)};
      eb[k] = word_ref(fb[k]);
      fd[k] = {16'h0002, 16'h0000, 16'hFFF0, 16'h0AAA};
      ed[k] = {16'h0003, 16'h0000, 16'h0000, 16'h0FFF};
    end
    fa[5] = {16'h7FFF, 16'hFFFF, 16'h0003, 16'h8000};
    ea[5] = {16'h7FFF, 16'h0000, 16'h0004, 16'h0000};

    tick();
    tick();
    check("rst_finish", {63'd0, finish}, 64'd0);
    check("rst_dout", dout, 64'd0);
    rst = 1'b0;
    tick();

    // Frame A: dropped write at 25, start pulse mid-compute.
    load_frame(fa, 1'b1);
    wait_finish(1'b1);
    read_all(ea);

    // Hold check: dout keeps its value with en_out low.
    out_addr = 5'd0;
    en_out   = 1'b1;
    tick();
    en_out   = 1'b0;
    out_addr = 5'd5;
    tick();
    tick();
    check("dout_hold", dout, 64'h0180_0180_0180_0180);
    check("finish_hold", {63'd0, finish}, 64'd1);

    // Frame B from DONE, reset part way through compute.
    load_frame(fb, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("pre_rst_finish", {63'd0, finish}, 64'd0);
    rst = 1'b1;
    tick();
    check("midrst_finish", {63'd0, finish}, 64'd0);
    check("midrst_dout", dout, 64'd0);
    rst = 1'b0;
    tick();

    // Frame C: same data as B, full run after reset.
    load_frame(fb, 1'b0);
    wait_finish(1'b0);
    read_all(eb);

    // Frame D: immediate reload, results independent of prior frame.
    load_frame(fd, 1'b0);
    wait_finish(1'b0);
    read_all(ed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_scale_buffer.md
# relu_scale_buffer

Word buffer and compute stage between the AXIS DMA controller and the S2MM FIFO. It loads MEM_DEPTH 64-bit words written by the controller and applies a per-lane fixed-point scale plus ReLU to every word in place. It then signals completion and serves the results back on a registered read port. The controller drives it with a level-high load strobe and collects results one word per cycle.

## Interface
- MEM_DEPTH, 21, number of words loaded, processed and read back
- ADDR_WIDTH, 5, address width; MEM_DEPTH ≤ 2**ADDR_WIDTH
- DATA_WIDTH, 64, word width; fixed at 4 lanes × 16 bits
- SCALE, 384, signed 16-bit multiplier applied to every lane
- SHIFT, 8, arithmetic right shift applied after the multiply
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  level-high load strobe: while high, din is written at in_addr each cycle
- in_addr  in  ADDR_WIDTH  write address during load
- din  in  DATA_WIDTH  write data during load
- finish  out  1  high while processed results are valid; reset 0
- en_out  in  1  read enable
- out_addr  in  ADDR_WIDTH  read address
- dout  out  DATA_WIDTH  registered read data; reset 0

## Operation
- States: IDLE, LOAD, COMPUTE, DONE. Reset enters IDLE.
- IDLE/DONE + start=1 → LOAD.
  - The word on that same edge is written.
  - finish clears on that edge.
- LOAD: each cycle with start=1 writes mem[in_addr] ← din. The first cycle with start=0 → COMPUTE.
- COMPUTE: a 2-stage pipeline walks addresses 0..MEM_DEPTH-1, one word issued per cycle.
  - Stage 1 reads mem[k].
  - Stage 2 computes the 4 lanes and writes the result back to mem[k].
  - After the last write → DONE with finish=1.
- Lane math (lane j = din[16j+15:16j], signed):
  - p = lane × SCALE as a 32-bit signed product.
  - q = p >>> SHIFT.
  - Result = 0 if q < 0, 16'h7FFF if q > 32767, else q[15:0].
- Read: on a cycle with en_out=1, dout ← mem[out_addr] on the next edge. With en_out=0, dout holds.
- Boundaries:
  - in_addr ≥ MEM_DEPTH during LOAD: the write is dropped.
  - out_addr ≥ MEM_DEPTH with en_out=1: dout ← 0.
  - start=1 in COMPUTE: ignored; there is no restart mid-compute.
  - en_out=1 in LOAD/COMPUTE: a read is performed but the data is unspecified; the controller must only read when finish=1.
  - A LOAD of zero words (start high for 0 cycles) is impossible, since LOAD needs start=1.
  - rst mid-operation: state IDLE, finish=0, dout=0, pipeline flushed; memory contents are not cleared.

## Timing
- Load: one word per cycle with no back-pressure, and no gaps required (gaps are allowed while start stays high).
- Let C be the first cycle with start=0 after LOAD.
  - Last write-back occurs on edge C+MEM_DEPTH+1.
  - finish is 1 from cycle C+MEM_DEPTH+2.
  - With defaults, 23 cycles after start falls.
- finish stays high until the next start=1 or rst.
- Read latency is 1 cycle (en_out at cycle t → dout valid at t+1). This matches the controller's one-cycle registered S2MM valid/last.
- Reads are back-to-back: MEM_DEPTH consecutive en_out cycles yield MEM_DEPTH consecutive dout words.

## Structure
- Shared package holds:
  - lane width (16) and lane count (4)
  - the state enum {IDLE, LOAD, COMPUTE, DONE}
  - saturation constants LANE_MAX=16'h7FFF and LANE_MIN=0
- Sub-module lane_relu_scale:
  - one lane, combinational multiply/shift/clip
  - parameterised by SCALE and SHIFT
  - instantiated 4× in stage 2
- Memory is a single inferred array with one write port, muxed between LOAD and compute write-back, and two read addresses (compute stage 1 and out_addr).

## Test plan
- Load 21 words, word k = {4{16'h0100}} → after finish, reading 0..20 returns {4{16'h0180}} on each word, 1 cycle after en_out.
- Lanes {16'h7FFF, 16'hFFFF, 16'h0003, 16'h8000} → {16'h7FFF, 16'h0000, 16'h0004, 16'h0000}, covering saturation, ReLU and truncating shift.
- Count cycles from start falling → finish rises exactly 23 cycles later; finish stays 0 throughout LOAD and COMPUTE.
- rst asserted at compute cycle 10 → next cycle finish=0, dout=0. A new 21-word load then completes normally with correct results.
- in_addr=25 written during load, then en_out with out_addr=21 → memory unchanged and dout=0. A start pulse during COMPUTE does not alter the finish timing.
- Two back-to-back frames (readout, then immediate reload) → finish drops on the first start edge, and the second frame's results are independent of the first.
